// File: rtl/pe_pkg.sv
// Shared PE definitions: datapath widths common to the PE adder and its
// accumulation controller, plus the controller's state encoding.
package pe_pkg;

  localparam int SUM_W  = 20;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } pe_state_e;

endpackage

// File: rtl/pe_accum_ctrl_if.sv
// Product-beat and result handshakes between the accumulation controller,
// its PE adder (previous_sum/pe_sum loop) and the upstream/downstream stages.
interface pe_accum_ctrl_if #(
  parameter int SUM_W = pe_pkg::SUM_W
);

  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] previous_sum;
  logic [SUM_W-1:0] pe_sum;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             done;

  modport slave (
    input  in_valid, pe_sum, out_ready,
    output in_ready, previous_sum, out_valid, out_sum, done
  );

  modport master (
    output in_valid, pe_sum, out_ready,
    input  in_ready, previous_sum, out_valid, out_sum, done
  );

endinterface

// File: rtl/pe_accum_ctrl.sv
// Sequencer for one PE reduction: feeds acc to the adder, captures its sum on
// each accepted beat, and hands the finished result downstream.
module pe_accum_ctrl #(
  parameter int SUM_W = pe_pkg::SUM_W,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic                  clear,
  output logic                  busy,
  output logic [CNT_W-1:0]      step_cnt,
  pe_accum_ctrl_if.slave        bus
);

  import pe_pkg::*;

  pe_state_e        state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             beat;
  logic             last_beat;

  assign beat      = in_ready_q && bus.in_valid;
  assign last_beat = beat && (cnt == len - CNT_W'(1));

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; clear shares the reset branch for priority.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      len         <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            len    <= cfg_len;
            busy_q <= 1'b1;
            if (cfg_len == '0) begin
              state       <= OUT;
              out_valid_q <= 1'b1;
            end else begin
              state      <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (beat) begin
            // The adder already wrapped modulo 2^SUM_W; just capture it.
            acc <= bus.pe_sum;
            cnt <= cnt + CNT_W'(1);
            if (last_beat) begin
              state       <= OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign step_cnt         = cnt;
  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.previous_sum = acc;
  assign bus.out_sum      = acc;

  // done marks the handshake cycle itself, so it cannot be registered; an
  // abort in that same cycle discards the result and suppresses the pulse.
  assign bus.done = out_valid_q && bus.out_ready && rst_n && !clear;

endmodule

// File: tb/tb_pe_accum_ctrl.sv
// Directed bench for pe_accum_ctrl with a behavioural PE adder closing the
// previous_sum -> pe_sum loop (pe_sum = previous_sum + delta).
module tb_pe_accum_ctrl;

  import pe_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] cfg_len;
  logic             clear;
  logic             busy;
  logic [CNT_W-1:0] step_cnt;
  logic [SUM_W-1:0] delta;

  int n_checks = 0;
  int n_fail   = 0;

  pe_accum_ctrl_if #(.SUM_W(SUM_W)) bus ();

  assign bus.pe_sum = bus.previous_sum + delta;

  pe_accum_ctrl #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .clear    (clear),
    .busy     (busy),
    .step_cnt (step_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] len;
    logic             iv;
    logic [SUM_W-1:0] d;
    logic             ordy;
    logic             busy;
    logic             inr;
    logic             ov;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             done;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic s, input logic [CNT_W-1:0] l, input logic iv,
                       input logic [SUM_W-1:0] d, input logic ordy);
    start         = s;
    cfg_len       = l;
    bus.in_valid  = iv;
    delta         = d;
    bus.out_ready = ordy;
  endtask

  // Compare outputs mid-cycle, then advance to just after the next edge.
  task automatic chk_cycle(input string tag, input logic b, input logic inr, input logic ov,
                           input logic [SUM_W-1:0] acc, input logic [CNT_W-1:0] cnt,
                           input logic dn);
    @(negedge clk);
    check({tag, ".busy"},         32'(busy),             32'(b));
    check({tag, ".in_ready"},     32'(bus.in_ready),     32'(inr));
    check({tag, ".out_valid"},    32'(bus.out_valid),    32'(ov));
    check({tag, ".out_sum"},      32'(bus.out_sum),      32'(acc));
    check({tag, ".previous_sum"}, 32'(bus.previous_sum), 32'(acc));
    check({tag, ".step_cnt"},     32'(step_cnt),         32'(cnt));
    check({tag, ".done"},         32'(bus.done),         32'(dn));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // start, len, in_valid, delta, out_ready | busy, in_ready, out_valid, acc, step_cnt, done
    tbl[0]  = '{1'b1, 16'd0, 1'b1, 20'd5,       1'b0, 1'b0, 1'b0, 1'b0, 20'd0,       16'd0, 1'b0};
    tbl[1]  = '{1'b0, 16'd0, 1'b1, 20'd5,       1'b0, 1'b1, 1'b0, 1'b1, 20'd0,       16'd0, 1'b0};
    tbl[2]  = '{1'b0, 16'd0, 1'b0, 20'd0,       1'b1, 1'b1, 1'b0, 1'b1, 20'd0,       16'd0, 1'b1};
    tbl[3]  = '{1'b1, 16'd3, 1'b0, 20'd0,       1'b0, 1'b0, 1'b0, 1'b0, 20'd0,       16'd0, 1'b0};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 20'd100,     1'b0, 1'b1, 1'b1, 1'b0, 20'd0,       16'd0, 1'b0};
    tbl[5]  = '{1'b0, 16'd0, 1'b1, 20'd100,     1'b0, 1'b1, 1'b1, 1'b0, 20'd100,     16'd1, 1'b0};
    tbl[6]  = '{1'b1, 16'd7, 1'b1, 20'd100,     1'b0, 1'b1, 1'b1, 1'b0, 20'd200,     16'd2, 1'b0};
    tbl[7]  = '{1'b1, 16'd1, 1'b0, 20'd0,       1'b1, 1'b1, 1'b0, 1'b1, 20'h0012C,   16'd3, 1'b1};
    tbl[8]  = '{1'b0, 16'd0, 1'b0, 20'd0,       1'b0, 1'b0, 1'b0, 1'b0, 20'h0012C,   16'd3, 1'b0};
    tbl[9]  = '{1'b1, 16'd2, 1'b0, 20'd0,       1'b0, 1'b0, 1'b0, 1'b0, 20'h0012C,   16'd3, 1'b0};
    tbl[10] = '{1'b0, 16'd0, 1'b1, 20'hFFFFB,   1'b0, 1'b1, 1'b1, 1'b0, 20'd0,       16'd0, 1'b0};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 20'hFFFF9,   1'b0, 1'b1, 1'b1, 1'b0, 20'hFFFFB,   16'd1, 1'b0};
    tbl[12] = '{1'b0, 16'd0, 1'b0, 20'd0,       1'b1, 1'b1, 1'b0, 1'b1, 20'hFFFF4,   16'd2, 1'b1};
    tbl[13] = '{1'b1, 16'd2, 1'b0, 20'd0,       1'b0, 1'b0, 1'b0, 1'b0, 20'hFFFF4,   16'd2, 1'b0};
    tbl[14] = '{1'b0, 16'd0, 1'b1, 20'h7FFFF,   1'b0, 1'b1, 1'b1, 1'b0, 20'd0,       16'd0, 1'b0};
    tbl[15] = '{1'b0, 16'd0, 1'b1, 20'd1,       1'b0, 1'b1, 1'b1, 1'b0, 20'h7FFFF,   16'd1, 1'b0};
    tbl[16] = '{1'b0, 16'd0, 1'b0, 20'd0,       1'b1, 1'b1, 1'b0, 1'b1, 20'h80000,   16'd2, 1'b1};
    tbl[17] = '{1'b1, 16'd1, 1'b0, 20'd0,       1'b0, 1'b0, 1'b0, 1'b0, 20'h80000,   16'd2, 1'b0};
    tbl[18] = '{1'b0, 16'd0, 1'b1, 20'd3,       1'b0, 1'b1, 1'b1, 1'b0, 20'd0,       16'd0, 1'b0};
    tbl[19] = '{1'b0, 16'd0, 1'b0, 20'd0,       1'b1, 1'b1, 1'b0, 1'b1, 20'd3,       16'd1, 1'b1};
    tbl[20] = '{1'b0, 16'd0, 1'b0, 20'd0,       1'b0, 1'b0, 1'b0, 1'b0, 20'd3,       16'd1, 1'b0};

    rst_n = 1'b0;
    clear = 1'b0;
    apply(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;

    // Zero-length, basic, ignored starts, negative sums, wrap, single beat.
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].start, tbl[i].len, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk_cycle($sformatf("row%0d", i), tbl[i].busy, tbl[i].inr, tbl[i].ov,
                tbl[i].acc, tbl[i].cnt, tbl[i].done);
    end

    // Upstream stalls: pattern 1,0,0,1,1,0,1 delivers exactly four beats.
    begin
      logic             pv [7];
      logic [CNT_W-1:0] exp_cnt;
      pv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      apply(1'b1, 16'd4, 1'b0, '0, 1'b0);
      chk_cycle("stall.start", 1'b0, 1'b0, 1'b0, 20'd3, 16'd1, 1'b0);
      exp_cnt = '0;
      for (int k = 0; k < 7; k++) begin
        apply(1'b0, '0, pv[k], 20'd10, 1'b0);
        chk_cycle($sformatf("stall.k%0d", k), 1'b1, 1'b1, 1'b0,
                  SUM_W'(10 * int'(exp_cnt)), exp_cnt, 1'b0);
        if (pv[k]) exp_cnt = exp_cnt + 16'd1;
      end
    end

    // Downstream backpressure: result held stable, extra beats refused.
    for (int k = 0; k < 5; k++) begin
      apply(1'b0, '0, 1'b1, 20'd10, 1'b0);
      chk_cycle($sformatf("bp.k%0d", k), 1'b1, 1'b0, 1'b1, 20'd40, 16'd4, 1'b0);
    end
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    chk_cycle("bp.handshake", 1'b1, 1'b0, 1'b1, 20'd40, 16'd4, 1'b1);
    apply(1'b0, '0, 1'b0, '0, 1'b0);
    chk_cycle("bp.idle", 1'b0, 1'b0, 1'b0, 20'd40, 16'd4, 1'b0);

    // Soft clear after 2 of 5 beats.
    apply(1'b1, 16'd5, 1'b0, '0, 1'b0);
    chk_cycle("clr.start", 1'b0, 1'b0, 1'b0, 20'd40, 16'd4, 1'b0);
    apply(1'b0, '0, 1'b1, 20'd7, 1'b0);
    chk_cycle("clr.b0", 1'b1, 1'b1, 1'b0, 20'd0, 16'd0, 1'b0);
    chk_cycle("clr.b1", 1'b1, 1'b1, 1'b0, 20'd7, 16'd1, 1'b0);
    clear = 1'b1;
    chk_cycle("clr.assert", 1'b1, 1'b1, 1'b0, 20'd14, 16'd2, 1'b0);
    clear = 1'b0;
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    chk_cycle("clr.after", 1'b0, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0);

    // Synchronous reset after 2 of 5 beats.
    apply(1'b1, 16'd5, 1'b0, '0, 1'b0);
    chk_cycle("rst.start", 1'b0, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0);
    apply(1'b0, '0, 1'b1, 20'd9, 1'b0);
    chk_cycle("rst.b0", 1'b1, 1'b1, 1'b0, 20'd0, 16'd0, 1'b0);
    chk_cycle("rst.b1", 1'b1, 1'b1, 1'b0, 20'd9, 16'd1, 1'b0);
    rst_n = 1'b0;
    chk_cycle("rst.assert", 1'b1, 1'b1, 1'b0, 20'd18, 16'd2, 1'b0);
    rst_n = 1'b1;
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    chk_cycle("rst.after", 1'b0, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0);

    // Fresh two-beat run; clear during the handshake discards it, no done.
    apply(1'b1, 16'd2, 1'b0, '0, 1'b0);
    chk_cycle("fresh.start", 1'b0, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0);
    apply(1'b0, '0, 1'b1, 20'd11, 1'b0);
    chk_cycle("fresh.b0", 1'b1, 1'b1, 1'b0, 20'd0, 16'd0, 1'b0);
    apply(1'b0, '0, 1'b1, 20'd22, 1'b0);
    chk_cycle("fresh.b1", 1'b1, 1'b1, 1'b0, 20'd11, 16'd1, 1'b0);
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    clear = 1'b1;
    chk_cycle("fresh.clr_hs", 1'b1, 1'b0, 1'b1, 20'd33, 16'd2, 1'b0);
    clear = 1'b0;
    chk_cycle("fresh.after", 1'b0, 1'b0, 1'b0, 20'd0, 16'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_accum_ctrl.md
Name: pe_accum_ctrl

Overview:
Sequencer for one PE's reduction datapath. It drives the combinational PE adder's previous_sum input from an internal accumulator and captures the adder's PE_sum result on every accepted product beat. After a programmed number of beats it presents the finished 20-bit dot-product result downstream on a valid/ready handshake. One instance sits beside each PE adder, between the fusion-unit product stage and the output buffer.

Parameters:
SUM_W, 20, accumulator/result width; matches the PE adder sum width
CNT_W, 16, width of the beat-count configuration and step counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a reduction; honoured only in IDLE
cfg_len  in  CNT_W  number of product beats in this reduction; sampled when start is accepted
clear  in  1  soft abort; synchronous, same effect as reset on state, acc and counter
busy  out  1  high in any state other than IDLE
in_valid  in  1  upstream product vector valid; adder inputs are stable while high
in_ready  out  1  controller accepts a beat this cycle
previous_sum  out  SUM_W  to adder previous_sum; equals acc
pe_sum  in  SUM_W  from adder PE_sum; combinational function of products and previous_sum
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_sum  out  SUM_W  final accumulated result, two's complement
step_cnt  out  CNT_W  beats accepted so far in the current reduction
done  out  1  one-cycle pulse on the cycle the result handshake completes

Behaviour:
- Reset or clear (rst_n==0 or clear==1 at a clk edge) sets state=IDLE, acc=0, step_cnt=0, len=0.
- Reset values of outputs: busy=0, in_ready=0, out_valid=0, done=0; out_sum=0 and previous_sum=0 because both equal acc.
- clear has priority over every other input; any in-flight result is discarded and done is not pulsed.
- States: IDLE, ACCUM, OUT.
- IDLE, start=1, cfg_len!=0: latch len=cfg_len, acc<=0, step_cnt<=0, next state ACCUM.
- IDLE, start=1, cfg_len==0: acc<=0, next state OUT. The result is 0.
- IDLE, start=0: hold.
- ACCUM: in_ready=1 combinationally.
  - On each beat (in_valid&&in_ready): acc<=pe_sum, step_cnt<=step_cnt+1.
  - If that beat is the last one (step_cnt==len-1): next state OUT.
  - No beat this cycle: hold. in_valid low stalls indefinitely with no timeout.
- OUT: in_ready=0, out_valid=1, out_sum=acc, held stable until out_ready.
  - On out_valid&&out_ready: done=1 for that cycle, next state IDLE. acc and step_cnt keep their values until the next start.
- start while not in IDLE is ignored; no queuing.
- A result handshake and a start in the same cycle do not chain: start is dropped, and the host must re-issue it once busy==0.
- Latency: the first beat can be accepted one cycle after start. A len-beat reduction with no stalls raises out_valid in cycle len+1 after start. Minimum turnaround from start to the next start is len+2 cycles.
- Arithmetic: acc wraps modulo 2^SUM_W, two's complement, with no saturation and no overflow flag. Wrap is exactly what the adder produces. The controller performs no addition itself.
- cfg_len changes are ignored outside the start-accept cycle.

Decomposition:
- Shared package pe_pkg holds:
  - SUM_W=20 and PROD_W=16 constants, shared with the PE adder;
  - the state enum {IDLE, ACCUM, OUT}.
- No sub-module is required. The acc register and step counter are inline.
- The verification top instantiates pe_accum_ctrl together with the existing PE adder, connecting previous_sum and pe_sum in a loop.

Test Plan:
1. Basic: start with cfg_len=3; three beats where each adder output adds +100 to previous_sum -> out_valid rises in cycle 4 after start; out_sum=300 (0x0012C); step_cnt=3; done pulses with out_ready=1.
2. Negative/wrap: cfg_len=2; beats add -5 then -7 -> out_sum=0xFFFF4 (-12). Separately, acc=0x7FFFF plus +1 -> 0x80000, with no flag raised.
3. Stalls and backpressure: cfg_len=4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats accepted. Hold out_ready=0 for 5 cycles -> out_valid and out_sum stay stable, done=0 until the handshake.
4. cfg_len=0 -> no in_ready; OUT entered the cycle after start; out_sum=0.
5. start=1 asserted during ACCUM and again during the OUT handshake cycle -> both ignored; busy drops; a later start with cfg_len=1 works normally.
6. clear, then rst_n=0, each asserted mid-ACCUM after 2 of 5 beats -> IDLE next cycle; acc=0, step_cnt=0, out_valid=0, no done. Then a fresh cfg_len=2 run produces the correct sum.
